// File: rtl/pixel_scheduler_pkg.sv
// pixel_scheduler_pkg: shared state, coordinate and color types for the pixel scheduler
package pixel_scheduler_pkg;
  localparam int H_RES_DEF = 64;
  localparam int V_RES_DEF = 48;
  localparam int COORD_W_DEF = 16;
  typedef logic [COORD_W_DEF-1:0] coord_t;
  typedef logic [23:0] color_t;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DONE, FLUSH} state_e;
endpackage

// File: rtl/pixel_scheduler_result_fifo.sv
// result_fifo: first-word-fall-through result buffer with occupancy count and flush
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 25,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic          rd_en,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [AW:0]   count
);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] count_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
    end else if (flush) begin
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) wp_q <= wp_q + AW'(1);
      if (rd_en) rp_q <= rp_q + AW'(1);
      count_q <= count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  always_ff @(posedge clk)
    if (wr_en && !flush) mem_q[wp_q] <= din;
  assign dout = mem_q[rp_q];
  assign count = count_q;
endmodule

// File: rtl/pixel_scheduler.sv
// pixel_scheduler: raster-order request issue to an iteration core with credit-limited result buffering
module pixel_scheduler import pixel_scheduler_pkg::*; #(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int COORD_W = COORD_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] x_min,
  input  logic [COORD_W-1:0] y_min,
  input  logic [COORD_W-1:0] step,
  output logic               req_valid,
  input  logic               req_ready,
  output logic [COORD_W-1:0] req_x,
  output logic [COORD_W-1:0] req_y,
  input  logic               res_valid,
  input  color_t             res_color,
  input  logic               res_is_mandel,
  output logic               out_valid,
  input  logic               out_ready,
  output color_t             out_color,
  output logic               out_is_mandel,
  output logic               out_last,
  output logic               busy,
  output logic               frame_done
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NPIX = H_RES * V_RES;
  localparam int IW = $clog2(NPIX) + 1;
  localparam int XW = $clog2(H_RES) + 1;
  localparam int YW = $clog2(V_RES) + 1;
  state_e state_q;
  logic [XW-1:0] col_q;
  logic [YW-1:0] row_q;
  logic [COORD_W-1:0] x_min_q, step_q, req_x_q, req_y_q;
  logic [CW-1:0] outst_q, fifo_count, used;
  logic [IW-1:0] out_idx_q;
  logic busy_q, done_q, active, req_fire, res_take, fifo_wr, flush, rd;
  logic [24:0] head;
  assign active = (state_q == ISSUE) || (state_q == DRAIN);
  assign used = outst_q + fifo_count;
  assign req_valid = (state_q == ISSUE) && !abort && (used < CW'(DEPTH));
  assign req_fire = req_valid && req_ready;
  // results with nothing outstanding are stale (e.g. after reset) and never counted
  assign res_take = res_valid && (outst_q != '0);
  assign flush = active && abort;
  assign fifo_wr = res_take && active && !abort;
  assign out_valid = fifo_count != '0;
  assign rd = out_valid && out_ready;
  assign out_color = out_valid ? head[23:0] : '0;
  assign out_is_mandel = out_valid && head[24];
  assign out_last = out_valid && (out_idx_q == IW'(NPIX - 1));
  assign req_x = req_x_q;
  assign req_y = req_y_q;
  assign busy = busy_q;
  assign frame_done = done_q;
  result_fifo #(.DEPTH(DEPTH), .W(25)) u_fifo (
    .clk(clk), .rst(n_rst), .flush(flush), .wr_en(fifo_wr), .rd_en(rd),
    .din({res_is_mandel, res_color}), .dout(head), .count(fifo_count)
  );
  always_ff @(posedge clk or posedge n_rst)
    if (n_rst) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      x_min_q <= '0;
      step_q <= '0;
      req_x_q <= '0;
      req_y_q <= '0;
      outst_q <= '0;
      out_idx_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      outst_q <= outst_q + CW'(req_fire) - CW'(res_take);
      if (rd) out_idx_q <= out_idx_q + IW'(1);
      if (req_fire) begin
        if (col_q == XW'(H_RES - 1)) begin
          col_q <= '0;
          row_q <= row_q + YW'(1);
          req_x_q <= x_min_q;
          req_y_q <= req_y_q + step_q;
        end else begin
          col_q <= col_q + XW'(1);
          req_x_q <= req_x_q + step_q;
        end
      end
      case (state_q)
        IDLE: if (start) begin
          state_q <= ISSUE;
          busy_q <= 1'b1;
          x_min_q <= x_min;
          step_q <= step;
          req_x_q <= x_min;
          req_y_q <= y_min;
          col_q <= '0;
          row_q <= '0;
          out_idx_q <= '0;
        end
        ISSUE: state_q <= abort ? FLUSH :
          (req_fire && col_q == XW'(H_RES - 1) && row_q == YW'(V_RES - 1)) ? DRAIN : ISSUE;
        DRAIN: if (abort) state_q <= FLUSH;
          else if (outst_q == '0 && fifo_count == '0) begin
            state_q <= DONE;
            done_q <= 1'b1;
          end
        DONE: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end
        FLUSH: if (outst_q == '0) begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pixel_scheduler.sv
// tb_pixel_scheduler: scoreboard bench with a latency-3 core model for a 4x2 frame
module tb_pixel_scheduler;
  import pixel_scheduler_pkg::*;
  logic clk = 0, n_rst = 1, start = 0, abort = 0, req_ready = 0, out_ready = 0;
  logic res_valid = 0, res_is_mandel = 0;
  color_t res_color = '0;
  coord_t x_min = '0, y_min = '0, step = '0;
  logic req_valid, out_valid, out_is_mandel, out_last, busy, frame_done;
  coord_t req_x, req_y;
  color_t out_color;
  int total = 0, bad = 0, fd_cnt = 0, pops = 0;
  logic [25:0] sbq[$];
  coord_t reqlog[$];
  logic [1:0] pv = '0;
  coord_t px0, px1, py0, py1;
  // {last, is_mandel, color}; core returns color={x[15:4],y[15:4]}, is_mandel=x[10]
  localparam logic [25:0] FA [8] = '{26'h0E00100, 26'h1E40100, 26'h0E80100, 26'h1EC0100,
                                     26'h0E00140, 26'h1E40140, 26'h0E80140, 26'h3EC0140};
  localparam logic [25:0] FW [8] = '{26'h17C0100, 26'h0800100, 26'h1840100, 26'h0880100,
                                     26'h17C0140, 26'h0800140, 26'h1840140, 26'h2880140};
  always #5 clk = ~clk;
  pixel_scheduler #(.H_RES(4), .V_RES(2), .COORD_W(16), .DEPTH(4)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
    .x_min(x_min), .y_min(y_min), .step(step),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .res_valid(res_valid), .res_color(res_color), .res_is_mandel(res_is_mandel),
    .out_valid(out_valid), .out_ready(out_ready), .out_color(out_color),
    .out_is_mandel(out_is_mandel), .out_last(out_last), .busy(busy), .frame_done(frame_done)
  );
  always @(posedge clk) begin
    pv <= {pv[0], req_valid && req_ready};
    px0 <= req_x; px1 <= px0;
    py0 <= req_y; py1 <= py0;
    res_valid <= pv[1];
    res_color <= {px1[15:4], py1[15:4]};
    res_is_mandel <= px1[10];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (req_valid && req_ready) reqlog.push_back(req_x);
    if (frame_done) fd_cnt++;
    if (out_valid && out_ready) begin
      pops++;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pixel: got %h want none", {out_last, out_is_mandel, out_color});
      end else chk("pixel", {6'd0, out_last, out_is_mandel, out_color}, {6'd0, sbq.pop_front()});
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_start(input coord_t x, input coord_t y, input coord_t s);
    x_min = x; y_min = y; step = s; start = 1;
    cyc(1);
    start = 0;
  endtask
  task automatic push_frame(input bit wrap);
    for (int i = 0; i < 8; i++) sbq.push_back(wrap ? FW[i] : FA[i]);
  endtask
  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = frame_done;
    end
    chk(name, {31'd0, seen}, 1);
    if (seen) begin
      @(negedge clk);
      chk("frame_done_width", {31'd0, frame_done}, 0);
      chk("busy_after_done", {31'd0, busy}, 0);
    end
    cyc(1);
  endtask
  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_valid"}, {31'd0, req_valid}, 0);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_out_last"}, {31'd0, out_last}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 0);
    chk({tag, "_req_xy"}, {req_x, req_y}, 0);
    chk({tag, "_out_data"}, {7'd0, out_is_mandel, out_color}, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int fd0, p0;
    bit seen;
    cyc(2);
    chk_reset_outs("rst");
    n_rst = 0;
    cyc(2);
    // basic frame
    req_ready = 1; out_ready = 1;
    reqlog.delete();
    push_frame(0);
    do_start(16'hE000, 16'h1000, 16'h0400);
    chk("busy_on_start", {31'd0, busy}, 1);
    wait_done("frameA_done");
    chk("frameA_reqs", reqlog.size(), 8);
    if (reqlog.size() == 8) begin
      chk("reqx0", reqlog[0], 16'hE000);
      chk("reqx1", reqlog[1], 16'hE400);
      chk("reqx2", reqlog[2], 16'hE800);
      chk("reqx3", reqlog[3], 16'hEC00);
      chk("reqx4_row1", reqlog[4], 16'hE000);
    end
    chk("frameA_pops", pops, 8);
    // backpressure
    out_ready = 0;
    reqlog.delete();
    push_frame(0);
    do_start(16'hE000, 16'h1000, 16'h0400);
    cyc(20);
    chk("bp_reqs", reqlog.size(), 4);
    chk("bp_req_valid", {31'd0, req_valid}, 0);
    chk("bp_out_valid", {31'd0, out_valid}, 1);
    out_ready = 1;
    wait_done("bp_done");
    chk("bp_reqs_total", reqlog.size(), 8);
    chk("bp_sb_empty", sbq.size(), 0);
    // coordinate wrap
    reqlog.delete();
    push_frame(1);
    do_start(16'h7C00, 16'h1000, 16'h0400);
    wait_done("wrap_done");
    if (reqlog.size() >= 3) begin
      chk("wrap_reqx1", reqlog[1], 16'h8000);
      chk("wrap_reqx2", reqlog[2], 16'h8400);
    end else chk("wrap_reqs", reqlog.size(), 8);
    // abort with 2 outstanding and 1 buffered
    out_ready = 0; req_ready = 0;
    reqlog.delete();
    fd0 = fd_cnt;
    do_start(16'hE000, 16'h1000, 16'h0400);
    req_ready = 1; cyc(1); req_ready = 0;
    cyc(5);
    chk("abort_buffered", {31'd0, out_valid}, 1);
    req_ready = 1; cyc(2); req_ready = 0;
    abort = 1;
    cyc(1);
    abort = 0;
    out_ready = 1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("abort_no_out", {31'd0, seen}, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = !busy;
    end
    chk("abort_idle", {31'd0, seen}, 1);
    chk("abort_no_done", fd_cnt, fd0);
    chk("abort_reqs", reqlog.size(), 3);
    cyc(1);
    // asynchronous reset mid-frame
    out_ready = 0; req_ready = 1;
    do_start(16'hE000, 16'h1000, 16'h0400);
    cyc(3);
    #2 n_rst = 1;
    #1 chk_reset_outs("async_rst");
    cyc(1);
    n_rst = 0;
    cyc(6);
    chk("post_rst_out_valid", {31'd0, out_valid}, 0);
    reqlog.delete();
    out_ready = 1;
    push_frame(0);
    do_start(16'hE000, 16'h1000, 16'h0400);
    wait_done("rst_restart_done");
    chk("rst_restart_reqs", reqlog.size(), 8);
    if (reqlog.size() > 0) chk("rst_restart_px0", reqlog[0], 16'hE000);
    // start while busy is ignored
    p0 = pops;
    push_frame(0);
    do_start(16'hE000, 16'h1000, 16'h0400);
    cyc(3);
    do_start(16'h7C00, 16'h0000, 16'h0400);
    wait_done("busy_start_done");
    chk("busy_start_pops", pops - p0, 8);
    cyc(5);
    chk("busy_start_idle", {31'd0, busy}, 0);
    chk("final_sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pixel_scheduler.md
PIXEL_SCHEDULER -- requirements
Module: pixel_scheduler

Interface
REQ-001 SHALL have parameter H_RES, default 64, pixels per row.
REQ-002 SHALL have parameter V_RES, default 48, rows per frame.
REQ-003 SHALL have parameter COORD_W, default 16, signed Q4.12 coordinate width.
REQ-004 SHALL have parameter DEPTH, default 4, result FIFO depth and credit limit (power of 2).
REQ-005 SHALL have clk  in  1  sole clock; all logic is rising-edge.
REQ-006 SHALL have n_rst  in  1  reset; one clock; reset is asynchronous and active-high (1 = reset asserted).
REQ-007 SHALL have start  in  1  one-cycle pulse, begin frame (ignored unless IDLE).
REQ-008 SHALL have abort  in  1  one-cycle pulse, terminate frame.
REQ-009 SHALL have x_min, y_min  in  COORD_W each  top-left coordinate; sampled on accepted start.
REQ-010 SHALL have step  in  COORD_W  pixel pitch; sampled on accepted start.
REQ-011 SHALL have req_valid  out  1, req_ready  in  1, req_x/req_y  out  COORD_W  compute request to iteration core.
REQ-012 SHALL have res_valid  in  1, res_color  in  24, res_is_mandel  in  1  in-order core result.
REQ-013 SHALL have out_valid  out  1, out_ready  in  1, out_color  out  24, out_is_mandel  out  1, out_last  out  1  pixel stream.
REQ-014 SHALL have busy  out  1 and frame_done  out  1 (one-cycle pulse).

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-016 IDLE: start=1 latches x_min/y_min/step, clears col/row, loads req_x=x_min, req_y=y_min, goes ISSUE next cycle.
REQ-017 ISSUE: req_valid=1 iff credits>0; transfer on req_valid&&req_ready.
REQ-018 On transfer: col+1, req_x+=step; at col=H_RES-1, col=0, row+1, req_x=x_min, req_y+=step.
REQ-019 Coordinate arithmetic SHALL wrap modulo 2^COORD_W (no saturation).
REQ-020 Transfer of pixel (H_RES-1, V_RES-1) SHALL move FSM to DRAIN.
REQ-021 Credits = DEPTH - outstanding - fifo_count; request SHALL never issue when credits=0, so FIFO never overflows.
REQ-022 res_valid SHALL always be accepted (no ready to core) and written to FIFO same cycle.
REQ-023 outstanding +1 on request transfer, -1 on res_valid; simultaneous = unchanged.
REQ-024 FIFO write and read same cycle SHALL be legal at any occupancy, including full and empty.
REQ-025 out_valid = FIFO non-empty; out_* driven from FIFO head (first-word-fall-through, 0 cycles).
REQ-026 out_last=1 with the pixel whose output index equals H_RES*V_RES-1.
REQ-027 DRAIN: exits to DONE when outstanding=0, FIFO empty, last pixel consumed.
REQ-028 DONE: frame_done=1 one cycle, then IDLE.
REQ-029 abort in ISSUE/DRAIN: stop issuing immediately, flush FIFO, discard subsequent res_valid until outstanding=0, then IDLE without frame_done.
REQ-030 busy=1 in every state except IDLE.
REQ-031 start while busy SHALL be ignored; abort in IDLE/DONE SHALL be ignored; abort and start same cycle in IDLE: start wins.

Reset
REQ-032 n_rst=1 SHALL force IDLE, all counters/pointers 0, FIFO empty.
REQ-033 Reset values: req_valid=0, out_valid=0, out_last=0, busy=0, frame_done=0, req_x=0, req_y=0, out_color=0, out_is_mandel=0.
REQ-034 Reset mid-frame SHALL discard all state; no output until next start.

Structure
REQ-035 Shared package SHALL hold FSM state enum, coordinate typedef (COORD_W), color typedef (24 bits), default H_RES/V_RES.
REQ-036 Result buffer SHALL be sub-module result_fifo (DEPTH x 25 bits, count output).

Verification
REQ-037 H_RES=4,V_RES=2,x_min=0xE000,y_min=0x1000,step=0x0400, ready always 1, core latency 3 -> 8 pixels in raster order, req_x sequence E000,E400,E800,EC00 per row, out_last on 8th, frame_done 1 cycle later.
REQ-038 out_ready=0 for 20 cycles -> exactly DEPTH=4 requests issued, FIFO full, no further req_valid; release -> stream resumes, no lost/duplicated pixel.
REQ-039 x_min=0x7C00, step=0x0400 -> second req_x=0x8000 (wrap), no saturation.
REQ-040 abort with 2 outstanding and 1 buffered -> no out_valid after abort+1, 2 results dropped, IDLE, no frame_done.
REQ-041 n_rst pulse during ISSUE -> all outputs at reset values asynchronously; start next -> frame restarts at pixel 0.
REQ-042 start pulse while busy -> ignored, frame completes with correct pixel count.
